inv_mix_columns_seq: RTL and testbench
======================================

# inv_mix_columns_seq

Iterative AES InvMixColumns engine for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and processes one 32-bit column per clock through a single GF(2^8) inverse-mix column unit. It presents the 128-bit result over a second valid/ready handshake. It is the inverse of the combinational column mixer used on the encryption side and sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round.

## Interface
- BYTE, 8, byte width
- DWORD, 32, column width
- LENGTH, 128, state width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  source has a state on in_state
- in_ready  output  1  engine can accept a state
- in_state  input  LENGTH  state to transform; column c = bits [LENGTH-1-32c -: 32]; within a column, row 0 is the MSB byte
- out_valid  output  1  out_state holds a finished result
- out_ready  input  1  sink accepts the result
- out_state  output  LENGTH  transformed state, same layout as in_state
- busy  output  1  high in RUN and DONE

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: 2-bit column counter col runs 0..3.
  - DONE: out_valid=1.
- IDLE -> RUN on in_valid & in_ready:
  - capture in_state into the working register;
  - col <= 0.
- RUN, each cycle:
  - transform column col of the working register and write it back in place;
  - col <= col+1;
  - when col==3, go to DONE. col wraps to 0 and is unused outside RUN.
- DONE -> IDLE on out_ready. While out_ready=0, hold DONE with out_state and out_valid stable.
- out_state is driven directly from the working register. Its value is defined only while out_valid=1.
- Column transform, with inputs a0..a3 (a0 = MSB byte) and outputs o0..o3:
  - o0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - o1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - o2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - o3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- GF(2^8) arithmetic:
  - xtime(b) = {b[6:0],0}, XORed with 8'h1B when b[7]=1.
  - With x2=xtime(b), x4=xtime(x2), x8=xtime(x4): 09=x8^b, 0b=x8^x2^b, 0d=x8^x4^b, 0e=x8^x4^x2.
  - All byte results are 8 bits. There is no carry out.
- in_state is sampled only at the input handshake. Changes on in_state outside that edge have no effect.
- in_valid while not in IDLE is ignored: in_ready=0, and the source holds its state.
- Reset (async, any time including mid-RUN or in DONE):
  - state=IDLE, col=0, working register=0;
  - out_valid=0, busy=0, in_ready=1 (in_ready is decoded from IDLE);
  - any in-flight transform is discarded without a result.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_state=0.
- Latency: input handshake at edge k.
  - Columns 0..3 are written at edges k+1..k+4.
  - out_valid=1 after edge k+4.
- Throughput:
  - Output handshake occurs at edge k+5 at the earliest.
  - in_ready=1 after that edge.
  - The next accept is at edge k+6 at the earliest, giving 6 cycles per state with out_ready tied high.
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid/out_ready.
- out_ready low for N cycles extends DONE by exactly N cycles.

## Test plan
- Reset, then a single transform:
  - Stimulus: in_state=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_ready=1.
  - Required: out_state=128'hdb135345_f20a225c_01010101_c6c6c6c6, with out_valid rising exactly 4 edges after the input handshake.
- Second vector:
  - Stimulus: in_state=128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff.
  - Required: out_state=128'hd4d4d4d5_2d26314c_00000000_ffffffff.
- Backpressure:
  - Stimulus: hold out_ready=0 for 7 cycles in DONE; toggle in_valid/in_state during that window.
  - Required: out_valid and out_state remain constant, in_ready=0, and no new capture occurs. Releasing out_ready gives one handshake and then IDLE.
- Back-to-back:
  - Stimulus: in_valid held high with two different states, out_ready=1.
  - Required: both results are correct and the accepts are 6 cycles apart.
- Reset mid-RUN:
  - Stimulus: assert rst asynchronously (between edges) after col=1.
  - Required: out_valid=0 and in_ready=1 immediately, with no spurious result afterward. A fresh transform then completes correctly.
- Randomized round-trip:
  - Stimulus: 1000 random states, each passed through a reference forward MixColumns model, with random valid/ready stalls.
  - Required: the engine returns the original state every time.

Source files
------------

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: a 128-bit state is transformed one 32-bit
// column per clock through a single GF(2^8) inverse-mix column unit.
module inv_mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned BYTE   = 8;
    localparam int unsigned DWORD  = 32;
    localparam int unsigned LENGTH = 128;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_col;
    logic [LENGTH-1:0]   r_work;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [DWORD-1:0]    w_col_in;
    logic [DWORD-1:0]    w_col_out;

    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
        return {b[BYTE-2:0], 1'b0} ^ (b[BYTE-1] ? 8'h1B : 8'h00);
    endfunction

    // Inverse column mix; the 09/0b/0d/0e multiples share one xtime chain per byte.
    function automatic logic [DWORD-1:0] inv_mix_col(input logic [DWORD-1:0] c);
        logic [BYTE-1:0] a  [4];
        logic [BYTE-1:0] m9 [4];
        logic [BYTE-1:0] mb [4];
        logic [BYTE-1:0] md [4];
        logic [BYTE-1:0] me [4];
        logic [BYTE-1:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[DWORD-1-BYTE*i -: BYTE];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        w_col_in = r_work[LENGTH-1 -: DWORD];
        case (r_col)
            2'd0:    w_col_in = r_work[LENGTH-1         -: DWORD];
            2'd1:    w_col_in = r_work[LENGTH-1-DWORD   -: DWORD];
            2'd2:    w_col_in = r_work[LENGTH-1-2*DWORD -: DWORD];
            default: w_col_in = r_work[LENGTH-1-3*DWORD -: DWORD];
        endcase
    end

    assign w_col_out = inv_mix_col(w_col_in);

    // Control FSM with handshake flags registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= 2'd0;
            r_work      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work     <= in_state;
                        r_col      <= 2'd0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    case (r_col)
                        2'd0:    r_work[LENGTH-1         -: DWORD] <= w_col_out;
                        2'd1:    r_work[LENGTH-1-DWORD   -: DWORD] <= w_col_out;
                        2'd2:    r_work[LENGTH-1-2*DWORD -: DWORD] <= w_col_out;
                        default: r_work[LENGTH-1-3*DWORD -: DWORD] <= w_col_out;
                    endcase
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_col       <= 2'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_state = r_work;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and randomized round-trip bench for inv_mix_columns_seq.
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] V2_OUT = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1B) : {b[6:0], 1'b0};
    endfunction

    // Forward MixColumns reference used to build round-trip stimulus.
    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until out_valid is seen; lat counts edges taken (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    initial begin
        int           lat;
        int           n;
        time          t0, t1;
        logic         bad;
        logic [127:0] x;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_out_state", out_state,       128'd0);
        rst = 1'b0;
        tick();

        // Single transform with latency measurement
        in_valid = 1'b1;
        in_state = V1_IN;
        tick();
        in_valid = 1'b0;
        in_state = '0;
        chk("v1_busy",     128'(busy),     128'd1);
        chk("v1_in_ready", 128'(in_ready), 128'd0);
        wait_out(lat);
        chk("v1_latency", 128'(lat), 128'd4);
        chk("v1_result",  out_state, V1_OUT);
        tick();
        chk("v1_out_valid_drop", 128'(out_valid), 128'd0);
        chk("v1_idle_ready",     128'(in_ready),  128'd1);
        chk("v1_idle_busy",      128'(busy),      128'd0);

        // Second vector with backpressure in DONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = V2_IN;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        chk("v2_latency", 128'(lat), 128'd4);
        chk("v2_result",  out_state, V2_OUT);
        bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = ~in_valid;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== V2_OUT) bad = 1'b1;
        end
        chk("bp_hold_stable", 128'(bad), 128'd0);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        chk("bp_release_ready", 128'(in_ready),  128'd1);
        chk("bp_release_busy",  128'(busy),      128'd0);

        // Back-to-back accepts with in_valid held high
        in_valid = 1'b1;
        in_state = V2_IN;
        tick();
        t0 = $time;
        in_state = V1_IN;
        wait_out(lat);
        chk("b2b_first", out_state, V2_OUT);
        n = 0;
        do begin
            tick();
            n++;
        end while (!in_ready && n < 10);
        tick();
        t1 = $time;
        in_valid = 1'b0;
        chk("b2b_gap", 128'(t1 - t0), 128'd60);
        wait_out(lat);
        chk("b2b_second", out_state, V1_OUT);
        tick();

        // Asynchronous reset in the middle of RUN
        in_valid = 1'b1;
        in_state = V1_IN;
        tick();
        in_valid = 1'b0;
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_in_ready",  128'(in_ready),  128'd1);
        chk("midrst_busy",      128'(busy),      128'd0);
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("midrst_no_spurious", 128'(bad), 128'd0);
        in_valid = 1'b1;
        in_state = V2_IN;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        chk("midrst_fresh_latency", 128'(lat), 128'd4);
        chk("midrst_fresh_result",  out_state, V2_OUT);
        tick();

        // Randomized round-trip through the forward reference
        for (int it = 0; it < 1000; it++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 2)) tick();
            in_valid = 1'b1;
            in_state = fwd_mix(x);
            tick();
            in_valid = 1'b0;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            wait_out(lat);
            out_ready = 1'b0;
            for (int k = 0; k < 20; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_ready) break;
                tick();
            end
            out_ready = 1'b1;
            chk("roundtrip", out_state, x);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
